// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard and forwarding unit: tracks in-flight register writes across
// DEPTH post-decode stages and resolves each source operand to a forward select or a stall.
module hazard_scoreboard #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ALU_STAGE  = 1,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned FLUSH_KILL = 0,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             pipe_hold,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [SEL_W-1:0] fwd_rs1_sel,
  output logic [SEL_W-1:0] fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [SEL_W-1:0] ALU_AVAIL  = SEL_W'(ALU_STAGE);
  localparam logic [SEL_W-1:0] LOAD_AVAIL = SEL_W'(LOAD_STAGE);
  // Bit i set when stage i+1 is killed by a flush.
  localparam logic [DEPTH-1:0] KILL_MASK  = DEPTH'((64'd1 << FLUSH_KILL) - 64'd1);

  // Index i holds stage i+1 (index 0 = EX).
  logic [DEPTH-1:0] ent_valid;
  logic [4:0]       ent_rd    [DEPTH];
  logic [SEL_W-1:0] ent_avail [DEPTH];

  logic             rs1_live;
  logic             rs2_live;
  logic             rs1_found;
  logic             rs2_found;
  logic             hazard_rs1;
  logic             hazard_rs2;
  logic [DEPTH-1:0] valid_kept;
  logic             rec_write;

  assign rs1_live = id_rs1_used && (id_rs1 != 5'd0);
  assign rs2_live = id_rs2_used && (id_rs2 != 5'd0);

  // Youngest live match decides each operand; an older ready copy is never used past it.
  always_comb begin
    rs1_found   = 1'b0;
    rs2_found   = 1'b0;
    hazard_rs1  = 1'b0;
    hazard_rs2  = 1'b0;
    fwd_rs1_sel = '0;
    fwd_rs2_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!rs1_found && rs1_live && ent_valid[i] && (ent_rd[i] == id_rs1)) begin
        rs1_found = 1'b1;
        if (SEL_W'(i + 1) >= ent_avail[i]) begin
          fwd_rs1_sel = SEL_W'(i + 1);
        end else begin
          hazard_rs1 = 1'b1;
        end
      end
      if (!rs2_found && rs2_live && ent_valid[i] && (ent_rd[i] == id_rs2)) begin
        rs2_found = 1'b1;
        if (SEL_W'(i + 1) >= ent_avail[i]) begin
          fwd_rs2_sel = SEL_W'(i + 1);
        end else begin
          hazard_rs2 = 1'b1;
        end
      end
    end
  end

  assign stall      = id_valid & (hazard_rs1 | hazard_rs2);
  assign issue      = id_valid & ~stall & ~pipe_hold & ~flush;
  assign rec_write  = issue & id_rd_we & (id_rd != 5'd0);
  assign valid_kept = ent_valid & ~({DEPTH{flush}} & KILL_MASK);

  // Entries shift one stage per cycle unless held; flush kills apply either way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_rd[i]    <= 5'd0;
        ent_avail[i] <= '0;
      end
    end else if (!pipe_hold) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        ent_valid[i] <= valid_kept[i-1];
        ent_rd[i]    <= ent_rd[i-1];
        ent_avail[i] <= ent_avail[i-1];
      end
      ent_valid[0] <= rec_write;
      if (rec_write) begin
        ent_rd[0]    <= id_rd;
        ent_avail[0] <= id_is_load ? LOAD_AVAIL : ALU_AVAIL;
      end
    end else begin
      ent_valid <= valid_kept;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the decode (ID) stage of the in-order RISC-V pipeline. It tracks every in-flight register write across a configurable number of post-decode stages. For each source operand it produces either a forwarding select or a stall. It supports per-class result latency, an external pipeline hold, a branch flush, and a saturating stall-cycle counter.

## Interface
- `DEPTH`, 3: post-decode stages tracked (stage 1 = EX … stage DEPTH = WB); ≥1.
- `ALU_STAGE`, 1: first stage at which ALU/LUI/AUIPC/JAL/JALR results are forwardable; 1..DEPTH.
- `LOAD_STAGE`, 2: first stage at which load data is forwardable; ALU_STAGE..DEPTH.
- `FLUSH_KILL`, 0: on `flush`, entries in stages 1..FLUSH_KILL are invalidated; 0..DEPTH-1.
- `CNT_W`, 32: stall counter width.
- Derived `SEL_W` = $clog2(DEPTH+1).
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  valid instruction in ID.
- `id_rs1`, `id_rs2`  in  5 each  source register indices.
- `id_rs1_used`, `id_rs2_used`  in  1 each  operand actually read.
- `id_rd`  in  5  destination index.
- `id_rd_we`  in  1  instruction writes `id_rd`.
- `id_is_load`  in  1  result class: 1 = load (LOAD_STAGE), 0 = ALU class (ALU_STAGE).
- `pipe_hold`  in  1  downstream stall; freezes the tracked pipeline.
- `flush`  in  1  kill ID instruction (and stages 1..FLUSH_KILL).
- `stall`  out  1  ID must not advance this cycle.
- `issue`  out  1  ID instruction enters stage 1 at next edge.
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  SEL_W each  0 = register file, k = forward from stage k.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall`=1.

## Operation
- State: per stage k ∈ 1..DEPTH, entry {valid, rd[4:0], avail[SEL_W-1:0]}. `avail` = ALU_STAGE or LOAD_STAGE, captured at issue. Entry is live iff valid and rd≠0; writes to x0 are never recorded as live.
- Operand match, per operand when `used`=1 and rs≠0: find the youngest live entry (lowest k) with rd = rs. No match → sel=0, no hazard. Match at k with k ≥ avail → sel=k. Match with k < avail → hazard, sel=0.
- Youngest match wins even if an older entry is ready. Older entries are never forwarded past a not-ready younger one.
- `stall` = id_valid & (hazard_rs1 | hazard_rs2). `stall` ignores `pipe_hold` and `flush`.
- `issue` = id_valid & ~stall & ~pipe_hold & ~flush.
- Update when `pipe_hold`=0: stage k+1 ← stage k for k<DEPTH. Stage 1 ← {1, id_rd, class avail} if `issue` & `id_rd_we`, else bubble (valid=0). The stage-DEPTH entry retires and is dropped.
- Update when `pipe_hold`=1: all entries hold.
- `flush`: entries in stages 1..FLUSH_KILL are invalidated, whether or not `pipe_hold` is asserted. With a shift, invalidated entries advance as bubbles. Flush takes priority over hold for these kills only.
- `stall_cnt` increments every cycle `stall`=1 and holds at all-ones.

## Timing
- `stall`, `issue` and both `fwd_*_sel` are combinational from ID inputs and registered entries. There is no added latency.
- Entry state and `stall_cnt` are registered and update on the rising `clk` edge.
- Reset (`rst_n` low, asynchronous, any cycle, including mid-stall): all entries invalid, `stall_cnt`=0. With entries empty, `stall`=0 and sel=0 whenever reset is asserted.
- Load-use spacing with defaults: a consumer immediately after a load stalls exactly 1 cycle, then forwards from stage 2. With LOAD_STAGE=L, the stall lasts L-1 cycles.
- Under `pipe_hold` the hazard does not resolve: `stall` stays 1 as long as the held entry has k < avail.
- Same rd in multiple stages: the lowest k is used. An entry in stage DEPTH remains forwardable until the cycle it retires.

## Test plan
- ALU forwarding: issue `add x5` (rd_we=1, is_load=0), then ID reads rs1=x5 → stall=0, fwd_rs1_sel=1. One cycle later (x5 in stage 2) → fwd_rs1_sel=2. After DEPTH+1 cycles → sel=0.
- Load-use: issue `lw x6`, next ID `add rs2=x6` → stall=1 for 1 cycle, issue=0, stall_cnt=1. Next cycle → stall=0, fwd_rs2_sel=2, issue=1.
- Priority and x0: two back-to-back writes to x7, then read x7 → sel=1. Any instruction with rd=x0 followed by a read of x0 → sel=0, stall=0.
- Hold and flush: `lw x8`, dependent in ID, `pipe_hold`=1 for 3 cycles → stall=1, entry still in stage 1. Then with FLUSH_KILL=1 and flush=1 → the x8 entry is invalidated, stall=0, issue=0.
- Reset mid-operation: 3 valid entries plus a pending stall, drive `rst_n` low between edges → stall=0, sel=0 and stall_cnt=0 immediately.
- Counter saturation: CNT_W=4, hold a load-use stall with `pipe_hold`=1 for 20 cycles → stall_cnt reaches 15 and stays 15.
